lsu_subword: RTL and testbench

Load/store unit between the core's execute stage and the 32-word data memory. It accepts one byte, halfword or word access per request over a valid/ready handshake. It converts the access into word-indexed memory reads and writes, doing read-modify-write for sub-word stores, and returns sign- or zero-extended load data with an error flag. It drives the data memory's `address`, `write_data` and `wrt_en` inputs and consumes its combinational `read_data`.

---
 rtl/lsu_subword.sv | 162 ++++++++++++++++
 tb/tb_lsu_subword.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword.sv
// Load/store unit: turns byte/half/word requests into word-indexed data memory
// accesses, with read-modify-write for sub-word stores and extended load data.
module lsu_subword #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_wrt_en,
    input  logic [31:0] mem_read_data,
    output logic [2:0]  dbg_state
);
    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // rsp_valid is a single-cycle strobe with no back-pressure.

    typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic        req_err;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;
    logic [31:0] store_word;

    always_comb begin
        req_err = 1'b0;
        if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11 || (req_we && req_funct3[2]))
            req_err = 1'b1;
        if (req_funct3[1:0] == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_funct3 == 3'b010 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (req_addr[31:2] >= WORD_LIMIT)
            req_err = 1'b1;
    end

    always_comb begin
        load_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        load_half = mem_read_data[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{16{load_half[15]}}, load_half};
            3'b100:  load_ext = {24'h0, load_byte};
            3'b101:  load_ext = {16'h0, load_half};
            default: load_ext = mem_read_data;
        endcase
    end

    // Sub-word stores replace only their lane of the word captured in RMW_READ.
    always_comb begin
        store_word = merge_q;
        case (funct3_q[1:0])
            2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        error_d  = error_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        rdata_d = 32'h0;
                        error_d = 1'b1;
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_funct3 == 3'b010) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_ext;
                error_d = 1'b0;
                state_d = RESP;
            end
            RMW_READ: begin
                merge_d = mem_read_data;
                state_d = WRITE;
            end
            WRITE: begin
                rdata_d = 32'h0;
                error_d = 1'b0;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            error_q  <= error_d;
        end
    end

    // Memory-side outputs decode the state directly, so an async reset
    // withdraws a write strobe in the same cycle.
    always_comb begin
        req_ready      = (state_q == IDLE);
        rsp_valid      = (state_q == RESP);
        rsp_rdata      = rdata_q;
        rsp_error      = error_q;
        mem_address    = (state_q == IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
        mem_wrt_en     = (state_q == WRITE) && we_q;
        mem_write_data = (state_q == WRITE) ? store_word : 32'h0;
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_lsu_subword.sv
// Bench for lsu_subword: directed cases plus random traffic against a
// byte-lane reference model, with a queue-based response/write scoreboard.
module tb_lsu_subword;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_wrt_en;
    logic [31:0] mem_read_data;
    logic [2:0]  dbg_state;

    lsu_subword #(.MEM_WORDS(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_wrt_en(mem_wrt_en), .mem_read_data(mem_read_data),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Data memory seen by the DUT
    logic [31:0] dmem [32];
    assign mem_read_data = (mem_address < 32) ? dmem[mem_address[4:0]] : 32'h0;
    always @(posedge clk)
        if (mem_wrt_en && mem_address < 32) dmem[mem_address[4:0]] <= mem_write_data;

    // Reference model state and scoreboard
    logic [31:0] ref_mem [32];
    logic [64:0] exp_q[$];   // {error, rdata, due cycle}
    logic [95:0] wr_q[$];    // {word index, data, due cycle}
    int tests = 0;
    int fails = 0;
    int ncyc = 0;
    int last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, ncyc);
        end
    endtask

    task automatic predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input int acc);
        logic        err;
        logic [31:0] word, res;
        logic [7:0]  b;
        logic [15:0] h;
        int idx, off, lat;
        idx = int'(addr >> 2);
        off = int'(addr & 32'h3);
        err = 1'b0;
        case (f3)
            3'b000, 3'b001, 3'b010: err = 1'b0;
            3'b100, 3'b101:         err = we;
            default:                err = 1'b1;
        endcase
        if ((f3 == 3'b001 || f3 == 3'b101) && (off % 2) != 0) err = 1'b1;
        if (f3 == 3'b010 && off != 0) err = 1'b1;
        if (addr >= 32'd128) err = 1'b1;
        if (err) begin
            exp_q.push_back({1'b1, 32'h0, 32'(acc + 1)});
        end else if (!we) begin
            word = ref_mem[idx];
            b = 8'(word >> (8 * off));
            h = 16'(word >> (16 * (off / 2)));
            case (f3)
                3'b000:  res = {{24{b[7]}}, b};
                3'b100:  res = {24'h0, b};
                3'b001:  res = {{16{h[15]}}, h};
                3'b101:  res = {16'h0, h};
                default: res = word;
            endcase
            exp_q.push_back({1'b0, res, 32'(acc + 2)});
        end else begin
            word = ref_mem[idx];
            lat = 3;
            if (f3 == 3'b000) word[8 * off +: 8] = wdata[7:0];
            else if (f3 == 3'b001) word[16 * (off / 2) +: 16] = wdata[15:0];
            else begin
                word = wdata;
                lat = 2;
            end
            ref_mem[idx] = word;
            wr_q.push_back({32'(idx), word, 32'(acc + lat - 1)});
            exp_q.push_back({1'b0, 32'h0, 32'(acc + lat)});
        end
    endtask

    // Presents a request and waits (bounded) for its accept edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic track);
        int waited;
        waited = 0;
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        while (!req_ready && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        if (!req_ready) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req_ready 0 for %0d cycles, required 1", waited);
            req_valid = 1'b0;
            return;
        end
        last_acc = ncyc;
        if (track) predict(we, f3, addr, wdata, ncyc);
        @(posedge clk);
    endtask

    task automatic drop_valid(input int gap);
        @(negedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < gap; i++) @(negedge clk);
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [64:0] e;
        logic [95:0] w;
        ncyc++;
        if (!rst) begin
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_rsp: rsp_valid 1 with nothing outstanding, cycle %0d", ncyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_error", {31'h0, rsp_error}, {31'h0, e[64]});
                    chk("rsp_rdata", rsp_rdata, e[63:32]);
                    chk("rsp_cycle", 32'(ncyc), e[31:0]);
                end
            end
            if (mem_wrt_en) begin
                if (wr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: mem_wrt_en 1 at index %0d, none expected", mem_address);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_address", mem_address, w[95:64]);
                    chk("wr_data", mem_write_data, w[63:32]);
                    chk("wr_cycle", 32'(ncyc), w[31:0]);
                end
            end
        end
    end

    initial begin
        int acc1, waited;
        logic [2:0]  f3;
        logic [31:0] addr;
        for (int i = 0; i < 32; i++) begin
            dmem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        #12;
        chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
        chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_error", {31'h0, rsp_error}, 32'h0);
        chk("reset_mem_wrt_en", {31'h0, mem_wrt_en}, 32'h0);
        chk("reset_mem_address", mem_address, 32'h0);
        chk("reset_mem_write_data", mem_write_data, 32'h0);
        @(negedge clk); #1;
        rst = 1'b0;

        // Store then loads of every width/extension
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b1);
        issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        // Sub-word read-modify-write
        issue(1'b1, 3'b000, 32'h11, 32'h00000055, 1'b1);
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1);
        issue(1'b1, 3'b001, 32'h12, 32'h00001234, 1'b1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        // Error cases
        issue(1'b0, 3'b010, 32'h02, 32'h0, 1'b1);
        issue(1'b0, 3'b001, 32'h01, 32'h0, 1'b1);
        issue(1'b1, 3'b010, 32'h80, 32'h11111111, 1'b1);
        issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h00, 32'h22222222, 1'b1);
        drop_valid(3);

        // Reset during the WRITE cycle of an SH
        issue(1'b1, 3'b001, 32'h12, 32'h0000ABCD, 1'b0);
        @(negedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_wrt_en_before", {31'h0, mem_wrt_en}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("abort_wrt_en_after", {31'h0, mem_wrt_en}, 32'h0);
        chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
        chk("abort_mem_address", mem_address, 32'h0);
        chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        @(negedge clk); #1;
        rst = 1'b0;
        drop_valid(2);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);

        // Back-to-back loads with req_valid held
        drop_valid(2);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        acc1 = last_acc;
        issue(1'b0, 3'b010, 32'h14, 32'h0, 1'b1);
        chk("b2b_accept_gap", 32'(last_acc - acc1), 32'd3);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            f3 = 3'($urandom_range(0, 7));
            addr = 32'($urandom_range(0, 36 * 4 - 1));
            if ($urandom_range(0, 19) == 0) addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3 == 3'b010) addr[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), f3, addr, $urandom, 1'b1);
            if ($urandom_range(0, 4) == 0) drop_valid($urandom_range(0, 3));
        end
        drop_valid(1);

        waited = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("drain_rsp_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_write_queue", 32'(wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
